// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester / UART-transmitter bundle shared by the TX arbiter.
//            master = requesters + UART side, slave = the arbiter itself.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_GW = $clog2(NUM_REQ);

    logic                   enable_uart;
    logic [NUM_REQ-1:0]     req;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     ack;
    logic [NUM_REQ-1:0]     done;
    logic [c_GW-1:0]        grant_id;
    logic                   busy;
    logic [7:0]             d_in;
    logic                   tx_send;
    logic                   enable_tx;
    logic                   tx_indicator;
    logic                   timeout_err;

    modport master (
        output enable_uart, req, req_data, tx_indicator,
        input  ack, done, grant_id, busy, d_in, tx_send, enable_tx, timeout_err
    );

    modport slave (
        input  enable_uart, req, req_data, tx_indicator,
        output ack, done, grant_id, busy, d_in, tx_send, enable_tx, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            byte requesters, with frame tracking and a start/finish watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SEND_CYCLES = 4,
    parameter int TIMEOUT     = 4096
) (
    input  wire logic         clock,
    input  wire logic         reset_uart,
    uart_tx_arbiter_if.slave  bus
);
    localparam int c_GW  = $clog2(NUM_REQ);
    localparam int c_SCW = $clog2(SEND_CYCLES + 1);

    localparam logic [c_SCW-1:0]   c_SEND_LAST = c_SCW'(SEND_CYCLES - 1);
    localparam logic [15:0]        c_TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] c_ONE       = {{(NUM_REQ-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_SEND       = 3'd1;
    localparam logic [2:0] c_WAIT_START = 3'd2;
    localparam logic [2:0] c_WAIT_DONE  = 3'd3;
    localparam logic [2:0] c_DONE       = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_GW-1:0]    r_grant_id;
    logic [c_GW-1:0]    r_last;
    logic [c_GW-1:0]    w_pick;
    logic               w_found;
    logic [7:0]         r_d_in;
    logic [c_SCW-1:0]   r_send_cnt;
    logic [15:0]        r_wd_cnt;
    logic               r_timeout_err;
    logic               w_grant;
    logic               w_send_last;
    logic               w_wd_expire;
    logic               w_abort;
    logic [NUM_REQ-1:0] w_ack;
    logic [NUM_REQ-1:0] w_done;
    logic               w_busy;
    logic               w_tx_send;
    logic               w_enable_tx;

    // A grant needs the global enable and a pending request, and only from IDLE
    assign w_grant     = (r_state == c_IDLE) && bus.enable_uart && w_found;
    assign w_send_last = (r_send_cnt == c_SEND_LAST);
    assign w_wd_expire = (r_wd_cnt == c_TO_LAST);
    // Abort only when the frame event the state is waiting for has not arrived
    assign w_abort     = w_wd_expire &&
                         (((r_state == c_WAIT_START) && !bus.tx_indicator) ||
                          ((r_state == c_WAIT_DONE)  &&  bus.tx_indicator));

    // Round-robin search starting just after the last granted requester
    always_comb begin : p_rr
        logic [c_GW-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = c_GW'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && bus.req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset_uart) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the frame event wins over a same-cycle watchdog expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:       if (w_grant) w_next = c_SEND;
            c_SEND:       if (w_send_last) w_next = c_WAIT_START;
            c_WAIT_START: begin
                if (bus.tx_indicator)  w_next = c_WAIT_DONE;
                else if (w_wd_expire)  w_next = c_IDLE;
            end
            c_WAIT_DONE:  begin
                if (!bus.tx_indicator) w_next = c_DONE;
                else if (w_wd_expire)  w_next = c_IDLE;
            end
            c_DONE:       w_next = c_IDLE;
            default:      w_next = c_IDLE;
        endcase
    end

    // Grant latch, send-cycle counter, watchdog counter and sticky error flag
    always_ff @(posedge clock) begin
        if (reset_uart) begin
            r_d_in        <= 8'd0;
            r_grant_id    <= '0;
            r_last        <= c_GW'(NUM_REQ - 1);
            r_send_cnt    <= '0;
            r_wd_cnt      <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_d_in     <= bus.req_data[{w_pick, 3'b000} +: 8];
                r_grant_id <= w_pick;
                r_last     <= w_pick;
            end
            if (r_state == c_SEND) begin
                r_send_cnt <= r_send_cnt + c_SCW'(1);
            end else begin
                r_send_cnt <= '0;
            end
            if (w_next != r_state) begin
                r_wd_cnt <= 16'd0;
            end else if ((r_state == c_WAIT_START) || (r_state == c_WAIT_DONE)) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        w_ack       = '0;
        w_done      = '0;
        w_busy      = 1'b0;
        w_tx_send   = 1'b0;
        w_enable_tx = 1'b0;
        case (r_state)
            c_SEND: begin
                w_busy      = 1'b1;
                w_enable_tx = 1'b1;
                w_tx_send   = 1'b1;
                if (r_send_cnt == '0) w_ack = c_ONE << r_grant_id;
            end
            c_WAIT_START, c_WAIT_DONE: begin
                w_busy      = 1'b1;
                w_enable_tx = 1'b1;
            end
            c_DONE: begin
                w_busy      = 1'b1;
                w_enable_tx = 1'b1;
                w_done      = c_ONE << r_grant_id;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bus.ack         = w_ack;
    assign bus.done        = w_done;
    assign bus.busy        = w_busy;
    assign bus.tx_send     = w_tx_send;
    assign bus.enable_tx   = w_enable_tx;
    assign bus.grant_id    = r_grant_id;
    assign bus.d_in        = r_d_in;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter: vector table of frames,
//            ack/done scoreboards, plus disable and mid-frame reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int SEND_CYCLES = 4;
    localparam int TIMEOUT     = 4096;

    logic clk = 1'b0;
    logic reset_uart;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .SEND_CYCLES (SEND_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock      (clk),
        .reset_uart (reset_uart),
        .bus        (bus)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] byte_v;
    } exp_t;

    typedef struct {
        bit          pre_reset;
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  exp_id;
        int          flen;      // 0 = tx_indicator never rises
        bit          en_drop;
        bit          exp_terr;
    } vec_t;

    exp_t       ack_q[$];
    logic [1:0] done_q[$];
    vec_t       vecs[12];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit pr, input logic [3:0] r, input logic [31:0] d,
                                input logic [1:0] id, input int fl, input bit ed, input bit te);
        vec_t v;
        v.pre_reset = pr; v.req = r; v.data = d; v.exp_id = id;
        v.flen = fl; v.en_drop = ed; v.exp_terr = te;
        return v;
    endfunction

    // Ack scoreboard: every ack pulse must match the next expected grant
    always @(negedge clk) begin : mon_ack
        exp_t e;
        if (bus.ack !== 4'b0000) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                e = ack_q.pop_front();
                check("ack_onehot", 32'(bus.ack), 32'(4'b0001 << e.id));
                check("grant_id", 32'(bus.grant_id), 32'(e.id));
                check("d_in", 32'(bus.d_in), 32'(e.byte_v));
            end
        end
    end

    // Done scoreboard: every done pulse must match the next expected frame end
    always @(negedge clk) begin : mon_done
        logic [1:0] id;
        if (bus.done !== 4'b0000) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                id = done_q.pop_front();
                check("done_onehot", 32'(bus.done), 32'(4'b0001 << id));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},       32'(bus.ack), 32'd0);
        check({tag, "_done"},      32'(bus.done), 32'd0);
        check({tag, "_busy"},      32'(bus.busy), 32'd0);
        check({tag, "_d_in"},      32'(bus.d_in), 32'd0);
        check({tag, "_grant_id"},  32'(bus.grant_id), 32'd0);
        check({tag, "_tx_send"},   32'(bus.tx_send), 32'd0);
        check({tag, "_enable_tx"}, 32'(bus.enable_tx), 32'd0);
        check({tag, "_terr"},      32'(bus.timeout_err), 32'd0);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ack === 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_latency", n, 0);
    endtask

    task automatic do_frame(input vec_t v);
        int   n;
        exp_t e;
        bus.req_data = v.data;
        bus.req      = v.req;
        e.id         = v.exp_id;
        e.byte_v     = v.data[8*v.exp_id +: 8];
        ack_q.push_back(e);
        if (v.flen > 0) done_q.push_back(v.exp_id);
        wait_ack();
        bus.req[v.exp_id] = 1'b0;
        check("enable_tx_send", 32'(bus.enable_tx), 32'd1);
        n = 0;
        while (bus.tx_send && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_send_len", n, SEND_CYCLES);
        if (v.flen == 0) begin
            n = 0;
            while (bus.busy && n < TIMEOUT + 100) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, TIMEOUT);
        end else begin
            bus.tx_indicator = 1'b1;
            for (int i = 0; i < v.flen; i++) begin
                @(negedge clk);
                if (v.en_drop && i == 2) bus.enable_uart = 1'b0;
            end
            bus.tx_indicator = 1'b0;
            n = 0;
            while (bus.busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("done_to_idle", n, 2);
            check("done_seen", done_q.size(), 0);
        end
        check("busy_after", 32'(bus.busy), 32'd0);
        check("timeout_err", 32'(bus.timeout_err), 32'(v.exp_terr));
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        reset_uart       = 1'b1;
        bus.enable_uart  = 1'b1;
        bus.req          = 4'b0000;
        bus.req_data     = 32'd0;
        bus.tx_indicator = 1'b0;

        vecs[0]  = mk(0, 4'b0001, 32'h0000_000F, 2'd0, 160, 0, 0);
        vecs[1]  = mk(1, 4'b1111, 32'hA3A2_A1A0, 2'd0, 20, 0, 0);
        vecs[2]  = mk(0, 4'b1111, 32'hA3A2_A1A0, 2'd1, 20, 0, 0);
        vecs[3]  = mk(0, 4'b1111, 32'hA3A2_A1A0, 2'd2, 20, 0, 0);
        vecs[4]  = mk(0, 4'b1111, 32'hA3A2_A1A0, 2'd3, 20, 0, 0);
        vecs[5]  = mk(0, 4'b1001, 32'h5566_7788, 2'd0, 12, 0, 0);
        vecs[6]  = mk(0, 4'b1001, 32'h5566_7788, 2'd3, 12, 0, 0);
        vecs[7]  = mk(0, 4'b0100, 32'h00C3_0000, 2'd2, 12, 0, 0);
        vecs[8]  = mk(0, 4'b0100, 32'h003C_0000, 2'd2, 12, 0, 0);
        vecs[9]  = mk(0, 4'b0010, 32'h0000_E100, 2'd1, 0,  0, 1);
        vecs[10] = mk(0, 4'b0100, 32'h0099_0000, 2'd2, 30, 0, 1);
        vecs[11] = mk(0, 4'b1000, 32'h7E00_0000, 2'd3, 40, 1, 1);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_uart = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].pre_reset) begin
                reset_uart = 1'b1;
                @(negedge clk);
                check_all_zero("rerst");
                reset_uart = 1'b0;
            end
            do_frame(vecs[i]);
        end

        // enable_uart is low after the last vector: a pending request must wait
        bus.req = 4'b0001;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy) n++;
        end
        check("grant_while_disabled", n, 0);
        bus.enable_uart = 1'b1;
        do_frame(mk(0, 4'b0001, 32'h0000_005A, 2'd0, 25, 0, 1));

        // Reset during WAIT_DONE abandons the frame without done
        bus.req_data = 32'h4433_2211;
        bus.req      = 4'b0010;
        ack_q.push_back('{id: 2'd1, byte_v: 8'h22});
        wait_ack();
        bus.req = 4'b0000;
        n = 0;
        while (bus.tx_send && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.tx_indicator = 1'b1;
        repeat (10) @(negedge clk);
        reset_uart = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        bus.tx_indicator = 1'b0;
        reset_uart = 1'b0;
        repeat (5) @(negedge clk);
        // Requester 0 has top priority again, so 1 wins over 2
        do_frame(mk(0, 4'b0110, 32'h0000_BB00, 2'd1, 20, 0, 0));

        check("ack_q_empty", ack_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmit side of the full-duplex UART among NUM_REQ byte requesters (e.g. DDS status/readback sources) using round-robin arbitration.
- Latches the granted byte and drives d_in/tx_send/enable_tx into the UART.
- Tracks the frame through tx_indicator and reports per-requester completion.
- Watchdog flags a transmitter that never starts or never finishes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEND_CYCLES, 4, number of cycles tx_send is held high per byte (≥1).
- TIMEOUT, 4096, max cycles in WAIT_START and in WAIT_DONE (each) before abort.

Ports:
- clock  in  1  system clock.
- reset_uart  in  1  synchronous reset, active-high.
- enable_uart  in  1  global enable; 0 blocks new grants only.
- req  in  NUM_REQ  per-requester byte-pending level; held until ack.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- ack  out  NUM_REQ  one-cycle one-hot pulse: byte accepted.
- done  out  NUM_REQ  one-cycle one-hot pulse: frame finished.
- grant_id  out  clog2(NUM_REQ)  index of current/last grant.
- busy  out  1  high in every state except IDLE.
- d_in  out  8  byte to UART transmitter.
- tx_send  out  1  UART send trigger.
- enable_tx  out  1  UART transmitter enable.
- tx_indicator  in  1  from UART; high while txd bits are being shifted.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (sync, reset_uart=1 at posedge):
  - state=IDLE; all outputs 0 (d_in=0, grant_id=0, timeout_err=0).
  - RR pointer set so requester 0 has highest priority next.
  - Reset has priority over any in-flight transaction; the frame is abandoned without ack or done.
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE, DONE.
- IDLE:
  - If enable_uart=1 and req≠0, grant the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - On that edge: latch req_data slice into d_in, set grant_id, pulse ack[grant] in the following cycle, go to SEND.
  - req is sampled only in IDLE; a req dropped before grant is ignored.
  - The same requester may re-request immediately but loses priority to any other pending requester.
- SEND:
  - tx_send=1 for exactly SEND_CYCLES cycles (first cycle coincides with the ack pulse), then 0; go to WAIT_START.
  - d_in is held stable from grant until return to IDLE.
- WAIT_START: stay until tx_indicator=1, then go to WAIT_DONE. If tx_indicator is already 1 on entry, transition on the next edge.
- WAIT_DONE: stay while tx_indicator=1. On tx_indicator=0, go to DONE.
- DONE: pulse done[grant_id] for one cycle, go to IDLE. Earliest new grant is evaluated in that IDLE cycle.
- enable_tx: 1 in SEND, WAIT_START, WAIT_DONE and DONE; 0 in IDLE.
- Watchdog:
  - A 16-bit counter clears on entry to WAIT_START and to WAIT_DONE and increments each cycle in those states.
  - When it reaches TIMEOUT: set timeout_err (sticky until reset), skip done, go directly to IDLE. The RR pointer still advances past the timed-out requester.
- enable_uart falling mid-transaction: the current frame completes normally; no new grant while low.
- Simultaneous events: a new req arriving in DONE waits for IDLE. Multiple reqs in one cycle resolve strictly by RR order.
- Throughput: at most one byte in flight; minimum grant-to-grant spacing = SEND_CYCLES + frame + 3 cycles.

Test Plan:
- Single request: req=0001, req_data[7:0]=0x0F. Expect ack=0001 one cycle after the sampling edge, d_in=0x0F, tx_send high exactly 4 cycles. Model tx_indicator high 160 cycles; expect done=0001 one cycle after it falls, then busy=0.
- Round-robin: req=1111 held, data 0xA0..0xA3. Expect grant order 0,1,2,3,0, with one ack and one done per frame and d_in matching each requester's byte.
- Wrap/priority: after granting 3, set req=1001. Expect requester 0 granted next, then 3. Requester 2 re-requesting alone after its own grant is granted again.
- Timeout: tx_indicator stuck 0 after SEND. Expect timeout_err=1 after 4096 WAIT_START cycles, no done, return to IDLE, next request still serviced with timeout_err held 1.
- enable_uart dropped during WAIT_DONE: expect the frame to finish with done pulsed and no further grants until enable_uart=1 again.
- reset_uart asserted during WAIT_DONE: expect all outputs 0 on the next edge, no done, requester 0 has priority afterwards, timeout_err cleared.
